// File: rtl/pattern_playback_sequencer.sv
// pattern_playback_sequencer
//
// Plays a stored game pattern onto eight one-hot LEDs. On a start request the
// packed pattern, the play direction and the clamped round length are captured.
// Each entry is then lit for ON_CYCLES cycles and followed by OFF_CYCLES blank
// cycles. A one-cycle done pulse tells the mode FSM that the input handler may
// be enabled.
//
// Ports
//   clk_i      system clock, rising edge
//   rst_i      asynchronous active-high reset
//   start_i    request playback; only honoured in IDLE or DONE
//   abort_i    synchronous cancel back to IDLE, highest priority
//   reverse_i  0: oldest entry first, 1: newest entry first (sampled with start)
//   length_i   number of valid entries, clamped to MAX_LEN at capture
//   pattern_i  packed 3-bit entries, newest at [2:0]
//   led_o      one-hot LED drive while an entry is shown, zero otherwise
//   busy_o     high while playback is running (ON or GAP)
//   done_o     one-cycle completion pulse
//   idx_o      play-order index of the entry being shown, 0 when idle
//
// State | meaning
// ------+-------------------------------------------------
// IDLE  | waiting for start
// ON    | current entry lit, timer counting down the on-time
// GAP   | LEDs blank, timer counting down the gap
// DONE  | single completion cycle; start here chains playback

module pattern_playback_sequencer #(
    parameter int MAX_LEN    = 25,
    parameter int ON_CYCLES  = 4,
    parameter int OFF_CYCLES = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic                   reverse_i,
    input  logic [15:0]            length_i,
    input  logic [3*MAX_LEN-1:0]   pattern_i,
    output logic [7:0]             led_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [15:0]            idx_o
);

    localparam int PW      = 3 * MAX_LEN;
    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);

    // The timer counts down to zero, so each phase loads its length minus one.
    localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LOAD = TW'((OFF_CYCLES > 0) ? (OFF_CYCLES - 1) : 0);
    localparam logic [15:0]   MAX_LEN_W = 16'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [15:0]     idx_q,   idx_d;
    logic [15:0]     len_q,   len_d;
    logic [PW-1:0]   pat_q,   pat_d;
    logic            rev_q,   rev_d;
    logic [7:0]      led_q,   led_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;

    logic [15:0]     clamp_len;
    logic            last_entry;
    logic [15:0]     pos;
    logic [2:0]      entry;

    assign clamp_len  = (length_i > MAX_LEN_W) ? MAX_LEN_W : length_i;
    assign last_entry = ((idx_q + 16'd1) >= len_q);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        len_d   = len_q;
        pat_d   = pat_q;
        rev_d   = rev_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    pat_d = pattern_i;
                    rev_d = reverse_i;
                    len_d = clamp_len;
                    idx_d = 16'd0;
                    if (clamp_len == 16'd0) begin
                        state_d = S_DONE;
                        timer_d = '0;
                    end else begin
                        state_d = S_ON;
                        timer_d = ON_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            end
            S_ON: begin
                if (timer_q == '0) begin
                    if (OFF_CYCLES > 0) begin
                        state_d = S_GAP;
                        timer_d = OFF_LOAD;
                    end else if (last_entry) begin
                        state_d = S_DONE;
                        idx_d   = 16'd0;
                        timer_d = '0;
                    end else begin
                        state_d = S_ON;
                        idx_d   = idx_q + 16'd1;
                        timer_d = ON_LOAD;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_GAP: begin
                if (timer_q == '0) begin
                    if (last_entry) begin
                        state_d = S_DONE;
                        idx_d   = 16'd0;
                        timer_d = '0;
                    end else begin
                        state_d = S_ON;
                        idx_d   = idx_q + 16'd1;
                        timer_d = ON_LOAD;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
                idx_d   = 16'd0;
            end
        endcase

        if (abort_i) begin
            state_d = S_IDLE;
            timer_d = '0;
            idx_d   = 16'd0;
        end
    end

    // Entry selection works on the next-cycle snapshot so the LED register
    // shows the right entry in the very first ON cycle after start.
    always_comb begin
        pos   = rev_d ? idx_d : (len_d - 16'd1 - idx_d);
        entry = 3'd0;
        for (int j = 0; j < MAX_LEN; j++) begin
            if (pos == 16'(j)) begin
                entry = pat_d[3*j +: 3];
            end
        end
    end

    always_comb begin
        led_d  = (state_d == S_ON) ? (8'b1 << entry) : 8'h00;
        busy_d = (state_d == S_ON) || (state_d == S_GAP);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            idx_q   <= 16'd0;
            len_q   <= 16'd0;
            pat_q   <= '0;
            rev_q   <= 1'b0;
            led_q   <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
            rev_q   <= rev_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign led_o  = led_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign idx_o  = idx_q;

endmodule
